commit_trace_buffer: RTL



---
 rtl/commit_trace_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 61 ++++++
 rtl/commit_trace_buffer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit-trace capture block: FSM states, FIFO entry layout
// and the default halting instruction (ebreak).
package commit_trace_pkg;

  localparam int unsigned PcWMax = 64;
  localparam logic [31:0] HaltInstDefault = 32'h00100073;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  // pc is sized for the widest supported XLEN; unused upper bits stay zero.
  typedef struct packed {
    logic [PcWMax-1:0] pc;
    logic [31:0]       inst;
    logic [63:0]       cycle;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with Lanes compacted write ports (lane 0 oldest) and one
// read port. The head and the count come straight from registers.
module trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int unsigned Lanes  = 2,
  parameter int unsigned Depth  = 16,
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CountW = $clog2(Depth) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic         [Lanes-1:0]       wr_en_i,
  input  trace_entry_t [Lanes-1:0]       wr_data_i,
  input  logic                           rd_en_i,
  output trace_entry_t                   head_o,
  output logic         [CountW-1:0]      count_o
);

  trace_entry_t mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic [CountW-1:0] n_wr;
  logic              rd_fire;

  always_comb begin
    n_wr = '0;
    for (int i = 0; i < Lanes; i++) begin
      if (wr_en_i[i]) begin
        n_wr = n_wr + CountW'(1);
      end
    end
    rd_fire = rd_en_i && (count_q != '0);
    count_d = count_q + n_wr - CountW'(rd_fire);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Enabled lanes are contiguous from lane 0, so lane i lands at wr_ptr + i.
      for (int i = 0; i < Lanes; i++) begin
        if (wr_en_i[i]) begin
          mem_q[wr_ptr_q + PtrW'(i)] <= wr_data_i[i];
        end
      end
      wr_ptr_q <= wr_ptr_q + n_wr[PtrW-1:0];
      rd_ptr_q <= rd_ptr_q + PtrW'(rd_fire);
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Multi-lane commit capture: IDLE/RUN/HALT control, run-cycle counter, group
// compaction with halt truncation, all-or-nothing enqueue and sticky overflow.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned COMMIT_W  = 2,
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] HALT_INST = HaltInstDefault
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_in_start,
  input  logic [COMMIT_W-1:0]        io_in_commit_valid,
  input  logic [COMMIT_W*XLEN-1:0]   io_in_commit_pc,
  input  logic [COMMIT_W*32-1:0]     io_in_commit_inst,
  output logic                       io_out_trace_valid,
  input  logic                       io_out_trace_ready,
  output logic [XLEN-1:0]            io_out_trace_pc,
  output logic [31:0]                io_out_trace_inst,
  output logic [63:0]                io_out_trace_cycle,
  output logic [$clog2(DEPTH):0]     io_out_count,
  output logic                       io_out_overflow,
  output logic                       io_out_halted,
  output logic [63:0]                io_out_mcycle
);

  localparam int unsigned CountW   = $clog2(DEPTH) + 1;
  localparam int unsigned LaneCntW = $clog2(COMMIT_W + 1);

  state_e            state_q, state_d;
  logic [63:0]       mcycle_q;
  logic              overflow_q, overflow_d;

  trace_entry_t [COMMIT_W-1:0] lane_entry;
  logic [COMMIT_W-1:0]         lane_keep;
  logic [LaneCntW-1:0]         lane_pos [COMMIT_W];
  trace_entry_t [COMMIT_W-1:0] grp_entry;
  logic [COMMIT_W-1:0]         grp_en;
  logic [LaneCntW-1:0]         grp_n;
  logic                        grp_halt;

  logic [COMMIT_W-1:0] fifo_wr_en;
  trace_entry_t        head;
  logic [CountW-1:0]   fifo_count;
  logic [CountW-1:0]   free_slots;
  logic                capture, fits;

  // Keep valid lanes up to and including the first halting instruction; each kept
  // lane's position in the compacted group is the number of kept lanes before it.
  always_comb begin
    lane_entry = '0;
    lane_keep  = '0;
    grp_n      = '0;
    grp_halt   = 1'b0;
    for (int i = 0; i < COMMIT_W; i++) begin
      lane_pos[i]        = grp_n;
      lane_entry[i].pc   = PcWMax'(io_in_commit_pc[i*XLEN +: XLEN]);
      lane_entry[i].inst = io_in_commit_inst[i*32 +: 32];
      lane_entry[i].cycle = mcycle_q;
      if (io_in_commit_valid[i] && !grp_halt) begin
        lane_keep[i] = 1'b1;
        grp_n        = grp_n + LaneCntW'(1);
        if (io_in_commit_inst[i*32 +: 32] == HALT_INST) begin
          grp_halt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grp_entry = '0;
    grp_en    = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (lane_keep[i] && (lane_pos[i] == LaneCntW'(j))) begin
          grp_entry[j] = lane_entry[i];
          grp_en[j]    = 1'b1;
        end
      end
    end
  end

  // Free space is judged on the registered count; a same-cycle dequeue does not help.
  always_comb begin
    free_slots = CountW'(DEPTH) - fifo_count;
    capture    = (state_q == StRun) && (grp_n != '0);
    fits       = CountW'(grp_n) <= free_slots;
    fifo_wr_en = (capture && fits) ? grp_en : '0;
    overflow_d = overflow_q | (capture & ~fits);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (io_in_start) state_d = StRun;
      StRun:   if (grp_halt) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      mcycle_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      if (state_q == StRun) begin
        mcycle_q <= mcycle_q + 64'd1;
      end
    end
  end

  trace_fifo #(
    .Lanes (COMMIT_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_ni    (reset),
    .wr_en_i   (fifo_wr_en),
    .wr_data_i (grp_entry),
    .rd_en_i   (io_out_trace_valid && io_out_trace_ready),
    .head_o    (head),
    .count_o   (fifo_count)
  );

  if (XLEN < PcWMax) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^head.pc[PcWMax-1:XLEN];
  end

  assign io_out_trace_valid = (fifo_count != '0);
  assign io_out_trace_pc    = head.pc[XLEN-1:0];
  assign io_out_trace_inst  = head.inst;
  assign io_out_trace_cycle = head.cycle;
  assign io_out_count       = fifo_count;
  assign io_out_overflow    = overflow_q;
  assign io_out_halted      = (state_q == StHalt);
  assign io_out_mcycle      = mcycle_q;

endmodule
